// File: rtl/mdarray_copy_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdarray_copy_engine: copies src[ROWS][COLS] into dst one element per  |
// | cycle, optionally reversing row and/or column index. Rev 1.0          |
// +----------------------------------------------------------------------+
module mdarray_copy_engine #(
  parameter int WIDTH = 1,
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [RW-1:0]    wr_row,
  input  logic [CW-1:0]    wr_col,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [RW-1:0]    rd_row,
  input  logic [CW-1:0]    rd_col,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  // Storage spans the full index space so every index is legal; the
  // entries beyond ROWS/COLS are never written and stay at reset value.
  localparam int RN = 1 << RW;
  localparam int CN = 1 << CW;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW:0]   ROWS_X   = (RW + 1)'(ROWS);
  localparam logic [CW:0]   COLS_X   = (CW + 1)'(COLS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [RW-1:0]    r_q, r_d;
  logic [CW-1:0]    c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] src_q [RN][CN];
  logic [WIDTH-1:0] src_d [RN][CN];
  logic [WIDTH-1:0] dst_q [RN][CN];
  logic [WIDTH-1:0] dst_d [RN][CN];

  logic [RW-1:0] r_dst;
  logic [CW-1:0] c_dst;
  logic          wr_ok;
  logic          rd_ok;

  assign r_dst = mode_q[1] ? (ROW_LAST - r_q) : r_q;
  assign c_dst = mode_q[0] ? (COL_LAST - c_q) : c_q;
  assign wr_ok = wr_en && (state_q != S_COPY) &&
                 ({1'b0, wr_row} < ROWS_X) && ({1'b0, wr_col} < COLS_X);
  assign rd_ok = ({1'b0, rd_row} < ROWS_X) && ({1'b0, rd_col} < COLS_X);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    r_d     = r_q;
    c_d     = c_q;
    src_d   = src_q;
    dst_d   = dst_q;

    // A write coinciding with an accepted start lands at the same edge,
    // so the copy that follows reads the new value.
    if (wr_ok) src_d[wr_row][wr_col] = wr_data;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          r_d     = '0;
          c_d     = '0;
          state_d = S_COPY;
        end
      end
      S_COPY: begin
        dst_d[r_dst][c_dst] = src_q[r_q][c_q];
        if (c_q == COL_LAST) begin
          c_d = '0;
          if (r_q == ROW_LAST) state_d = S_DONE;
          else                 r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_COPY);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      src_q   <= '{default: '0};
      dst_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  assign rd_data = rd_ok ? dst_q[rd_row][rd_col] : '0;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mdarray_copy_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mdarray_copy_engine: randomized bench with an array-level model.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mdarray_copy_engine;

  localparam int WIDTH = 8;
  localparam int ROWS  = 3;
  localparam int COLS  = 5;
  localparam int RW    = 2;
  localparam int CW    = 3;
  localparam int N     = ROWS * COLS;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [RW-1:0]    wr_row;
  logic [CW-1:0]    wr_col;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [1:0]       mode;
  logic [RW-1:0]    rd_row;
  logic [CW-1:0]    rd_col;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;

  mdarray_copy_engine #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .start(start), .mode(mode), .rd_row(rd_row),
    .rd_col(rd_col), .rd_data(rd_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] src_m [ROWS][COLS];
  logic [WIDTH-1:0] dst_m [ROWS][COLS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        src_m[r][c] = '0;
        dst_m[r][c] = '0;
      end
  endtask

  task automatic write_src(input int r, input int c, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_row = RW'(r); wr_col = CW'(c); wr_data = d;
    step();
    wr_en = 1'b0;
    if (r < ROWS && c < COLS) src_m[r][c] = d;
  endtask

  // Whole-array reference: each source element lands at its mirrored slot.
  task automatic model_copy(input logic [1:0] m);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        dst_m[m[1] ? ROWS-1-r : r][m[0] ? COLS-1-c : c] = src_m[r][c];
  endtask

  task automatic check_dst(input string tag);
    logic [WIDTH-1:0] exp;
    for (int r = 0; r < (1 << RW); r++)
      for (int c = 0; c < (1 << CW); c++) begin
        rd_row = RW'(r); rd_col = CW'(c);
        #1;
        exp = (r < ROWS && c < COLS) ? dst_m[r][c] : '0;
        check(tag, 32'(rd_data), 32'(exp));
      end
  endtask

  task automatic run_copy(input logic [1:0] m, input bit disturb, input bit with_write);
    int wr; int wc; logic [WIDTH-1:0] wd;
    if (with_write) begin
      wr = $urandom_range(ROWS-1); wc = $urandom_range(COLS-1); wd = WIDTH'($urandom);
      wr_en = 1'b1; wr_row = RW'(wr); wr_col = CW'(wc); wr_data = wd;
      src_m[wr][wc] = wd;
    end
    start = 1'b1; mode = m;
    step();                                   // E0
    wr_en = 1'b0; start = 1'b0; mode = 2'($urandom);
    check("busy_after_start", {30'd0, busy, done}, 32'b10);
    for (int k = 1; k < N; k++) begin
      if (disturb) begin
        start = 1'b1; wr_en = 1'b1;
        wr_row = RW'($urandom_range(ROWS-1)); wr_col = CW'($urandom_range(COLS-1));
        wr_data = WIDTH'($urandom);
      end
      step();                                 // E1..E(N-1)
      check("busy_during_copy", {30'd0, busy, done}, 32'b10);
    end
    step();                                   // EN
    wr_en = 1'b0;
    check("done_pulse", {30'd0, busy, done}, 32'b01);
    step();                                   // E(N+1), start still high if disturbed
    start = 1'b0;
    check("idle_after_done", {30'd0, busy, done}, 32'b00);
    step();
    check("start_not_queued", {30'd0, busy, done}, 32'b00);
    model_copy(m);
    check_dst("dst_contents");
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    start = 1'b0; mode = 2'b00; rd_row = '0; rd_col = '0;
    clear_model();
    #1;
    check("reset_outputs", {30'd0, busy, done}, 32'b00);
    check_dst("reset_dst");
    step();
    rst_n = 1'b1;
    step();

    // Directed: src[r][c] = 16r+c, plus writes outside the array.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        write_src(r, c, WIDTH'(16*r + c));
    write_src(3, 0, 8'hFF);
    write_src(0, 5, 8'hEE);
    write_src(2, 7, 8'hDD);
    run_copy(2'b00, 1'b0, 1'b0);
    run_copy(2'b10, 1'b0, 1'b0);
    run_copy(2'b01, 1'b0, 1'b0);
    run_copy(2'b11, 1'b1, 1'b0);
    run_copy(2'b00, 1'b0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          write_src(r, c, WIDTH'($urandom));
      run_copy(2'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a copy.
    start = 1'b1; mode = 2'b01;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("reset_mid_copy_outputs", {30'd0, busy, done}, 32'b00);
    clear_model();
    check_dst("reset_mid_copy_dst");
    #2;
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < N + 4; k++) begin
      step();
      if (done || busy) done_seen++;
    end
    check("no_done_after_reset", 32'(done_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
